// File: rtl/ltsm_active_pkg.sv
// Sideband message codes and shared LTSM types used by the ACTIVE-state controller.
package SB_codex_pkg;

  typedef enum logic [3:0] {
    SB_NO_MSG      = 4'h0,
    RETRAIN_REQ    = 4'h1,
    RETRAIN_RESP   = 4'h2,
    TRAINERROR_REQ = 4'h3,
    LINKMGMT_NOP   = 4'h4
  } SB_msg_t;

endpackage

package ltsm_active_pkg;

  localparam int unsigned LTSM_RETRY_MAX = 3;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ACTIVE    = 3'd1,
    ST_SEND_REQ  = 3'd2,
    ST_SEND_RESP = 3'd3,
    ST_SEND_TE   = 3'd4,
    ST_EXIT_RT   = 3'd5,
    ST_ERROR     = 3'd6
  } ltsm_active_state_t;

  typedef enum logic [1:0] {
    EXIT_NONE       = 2'd0,
    EXIT_RETRAIN    = 2'd1,
    EXIT_TRAINERROR = 2'd2
  } ltsm_exit_t;

endpackage

// File: rtl/ltsm_active_sb_req_retry.sv
// Sideband request sender: holds valid until accepted, re-arms on retry timeout
// up to RETRY_MAX times, then flags exhaustion to the owning state machine.
module sb_req_retry
  import ltsm_active_pkg::*;
#(
  parameter int unsigned RETRY_MAX = LTSM_RETRY_MAX
) (
  input  logic clk,
  input  logic rst_n,
  input  logic arm,
  input  logic send_next,
  input  logic retry_timeout,
  output logic valid,
  output logic timer_rst,
  output logic exhausted
);

  localparam int unsigned CW = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);

  logic          pending;
  logic          pulse;
  logic [CW-1:0] count;
  logic          timeout_seen;
  logic          retry_ok;

  // The timer may still report expiry while its reset pulse is in flight; ignore it then.
  assign timeout_seen = arm & retry_timeout & ~pulse;
  assign retry_ok     = (count < CW'(RETRY_MAX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= 1'b1;
      pulse   <= 1'b0;
      count   <= '0;
    end else if (!arm) begin
      pending <= 1'b1;
      pulse   <= 1'b0;
      count   <= '0;
    end else begin
      pulse <= 1'b0;
      if (timeout_seen && retry_ok) begin
        count   <= count + 1'b1;
        pending <= 1'b1;
        pulse   <= 1'b1;
      end else if (valid && send_next) begin
        pending <= 1'b0;
      end
    end
  end

  assign valid     = arm & pending;
  assign timer_rst = ~arm | pulse;
  assign exhausted = timeout_seen & ~retry_ok;

endmodule

// File: rtl/ltsm_active.sv
// LTSM ACTIVE-state controller: holds the link active and arbitrates sideband
// RETRAIN / TRAINERROR exits, reporting the decided exit to the top sequencer.
module ltsm_active
  import SB_codex_pkg::*;
  import ltsm_active_pkg::*;
#(
  parameter int unsigned RETRY_MAX = LTSM_RETRY_MAX
) (
  input  logic    clk_100MHz,
  input  logic    reset,
  input  logic    enable_i,
  input  logic    retrain_req_i,
  output logic    active_o,
  output logic    exit_retrain_o,
  output logic    exit_trainerror_o,
  output SB_msg_t SB_TX_msg_o,
  output logic    SB_TX_msg_valid_o,
  input  logic    SB_TX_msg_sendNextFlag_i,
  input  SB_msg_t SB_RX_msg_i,
  output logic    SB_RX_msg_req_o,
  input  logic    SB_RX_msg_valid_i,
  input  logic    SBmessage_retry_timeout_flag,
  output logic    reset_SBmessage_retry_timeout,
  input  logic    state_timeout_flag_i,
  output logic    reset_state_timeout_counter_o
);

  ltsm_active_state_t state, nxt;
  ltsm_exit_t         exit_cause;

  logic rx_open, rx_fire, tx_fire;
  logic req_arm, req_valid, req_timer_rst, req_exhausted;

  assign rx_open = (state == ST_ACTIVE) || (state == ST_SEND_REQ);
  assign rx_fire = rx_open & SB_RX_msg_valid_i;
  assign tx_fire = SB_TX_msg_valid_o & SB_TX_msg_sendNextFlag_i;
  assign req_arm = (state == ST_SEND_REQ);

  sb_req_retry #(
    .RETRY_MAX(RETRY_MAX)
  ) u_req_retry (
    .clk           (clk_100MHz),
    .rst_n         (reset),
    .arm           (req_arm),
    .send_next     (SB_TX_msg_sendNextFlag_i),
    .retry_timeout (SBmessage_retry_timeout_flag),
    .valid         (req_valid),
    .timer_rst     (req_timer_rst),
    .exhausted     (req_exhausted)
  );

  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    if (!enable_i) begin
      nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: nxt = ST_ACTIVE;
        ST_ACTIVE: begin
          // A remote RETRAIN_REQ absorbs any simultaneous local request.
          if (rx_fire && SB_RX_msg_i == RETRAIN_REQ)         nxt = ST_SEND_RESP;
          else if (rx_fire && SB_RX_msg_i == TRAINERROR_REQ) nxt = ST_ERROR;
          else if (retrain_req_i)                            nxt = ST_SEND_REQ;
        end
        ST_SEND_REQ: begin
          if (state_timeout_flag_i)                        nxt = ST_SEND_TE;
          else if (rx_fire && SB_RX_msg_i == RETRAIN_RESP) nxt = ST_EXIT_RT;
          else if (rx_fire && SB_RX_msg_i == RETRAIN_REQ)  nxt = ST_SEND_RESP;
          else if (req_exhausted)                          nxt = ST_SEND_TE;
        end
        ST_SEND_RESP: begin
          if (state_timeout_flag_i) nxt = ST_SEND_TE;
          else if (tx_fire)         nxt = ST_EXIT_RT;
        end
        ST_SEND_TE: begin
          if (tx_fire) nxt = ST_ERROR;
        end
        ST_EXIT_RT: nxt = ST_EXIT_RT;
        ST_ERROR:   nxt = ST_ERROR;
        default:    nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    active_o                      = 1'b0;
    exit_cause                    = EXIT_NONE;
    SB_TX_msg_o                   = SB_NO_MSG;
    SB_TX_msg_valid_o             = 1'b0;
    SB_RX_msg_req_o               = rx_open;
    reset_state_timeout_counter_o = 1'b1;
    case (state)
      ST_ACTIVE: active_o = 1'b1;
      ST_SEND_REQ: begin
        SB_TX_msg_o                   = RETRAIN_REQ;
        SB_TX_msg_valid_o             = req_valid;
        reset_state_timeout_counter_o = 1'b0;
      end
      ST_SEND_RESP: begin
        SB_TX_msg_o                   = RETRAIN_RESP;
        SB_TX_msg_valid_o             = 1'b1;
        reset_state_timeout_counter_o = 1'b0;
      end
      ST_SEND_TE: begin
        SB_TX_msg_o                   = TRAINERROR_REQ;
        SB_TX_msg_valid_o             = 1'b1;
        reset_state_timeout_counter_o = 1'b0;
      end
      ST_EXIT_RT: exit_cause = EXIT_RETRAIN;
      ST_ERROR:   exit_cause = EXIT_TRAINERROR;
      default:    ;
    endcase
  end

  assign exit_retrain_o                = (exit_cause == EXIT_RETRAIN);
  assign exit_trainerror_o             = (exit_cause == EXIT_TRAINERROR);
  assign reset_SBmessage_retry_timeout = req_timer_rst;

endmodule

// File: tb/tb_ltsm_active.sv
// Directed self-checking bench for the LTSM ACTIVE-state controller.
module tb_ltsm_active;
  import SB_codex_pkg::*;

  logic    clk, reset, enable_i, retrain_req_i;
  logic    active_o, exit_retrain_o, exit_trainerror_o;
  SB_msg_t tx_msg, rx_msg;
  logic    tx_valid, send_next, rx_req, rx_valid;
  logic    retry_to, reset_retry, state_to, reset_state;

  int checks = 0;
  int fails  = 0;

  ltsm_active #(.RETRY_MAX(3)) dut (
    .clk_100MHz                    (clk),
    .reset                         (reset),
    .enable_i                      (enable_i),
    .retrain_req_i                 (retrain_req_i),
    .active_o                      (active_o),
    .exit_retrain_o                (exit_retrain_o),
    .exit_trainerror_o             (exit_trainerror_o),
    .SB_TX_msg_o                   (tx_msg),
    .SB_TX_msg_valid_o             (tx_valid),
    .SB_TX_msg_sendNextFlag_i      (send_next),
    .SB_RX_msg_i                   (rx_msg),
    .SB_RX_msg_req_o               (rx_req),
    .SB_RX_msg_valid_i             (rx_valid),
    .SBmessage_retry_timeout_flag  (retry_to),
    .reset_SBmessage_retry_timeout (reset_retry),
    .state_timeout_flag_i          (state_to),
    .reset_state_timeout_counter_o (reset_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic go_active();
    enable_i = 1'b0;
    step();
    enable_i = 1'b1;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step(2);
    checks++; if (active_o !== 1'b0) begin fails++; $display("FAIL reset_active: got %0b want 0", active_o); end
    checks++; if ({exit_retrain_o, exit_trainerror_o} !== 2'b00) begin fails++; $display("FAIL reset_exits: got %b want 00", {exit_retrain_o, exit_trainerror_o}); end
    checks++; if ({tx_valid, rx_req} !== 2'b00) begin fails++; $display("FAIL reset_valid_req: got %b want 00", {tx_valid, rx_req}); end
    checks++; if (tx_msg !== SB_NO_MSG) begin fails++; $display("FAIL reset_msg: got %0h want 0", tx_msg); end
    checks++; if ({reset_retry, reset_state} !== 2'b11) begin fails++; $display("FAIL reset_timer_rst: got %b want 11", {reset_retry, reset_state}); end
    reset = 1'b1;
    step();
  endtask

  task automatic test_enable();
    int vcnt, acnt;
    enable_i = 1'b1;
    checks++; if (active_o !== 1'b0) begin fails++; $display("FAIL enable_cycle0: got %0b want 0", active_o); end
    step();
    checks++; if (active_o !== 1'b1) begin fails++; $display("FAIL enable_cycle1: got %0b want 1", active_o); end
    checks++; if ({rx_req, reset_retry, reset_state} !== 3'b111) begin fails++; $display("FAIL active_outputs: got %b want 111", {rx_req, reset_retry, reset_state}); end
    vcnt = 0; acnt = 0;
    for (int i = 0; i < 100; i++) begin
      rx_valid = (i == 40);
      rx_msg   = (i == 40) ? LINKMGMT_NOP : SB_NO_MSG;
      step();
      if (tx_valid) vcnt++;
      if (active_o) acnt++;
    end
    rx_valid = 1'b0;
    checks++; if (vcnt !== 0) begin fails++; $display("FAIL idle_tx_valid: got %0d cycles want 0", vcnt); end
    checks++; if (acnt !== 100) begin fails++; $display("FAIL active_hold: got %0d cycles want 100", acnt); end
  endtask

  task automatic test_local_retrain();
    retrain_req_i = 1'b1;
    step();
    retrain_req_i = 1'b0;
    checks++; if ({tx_valid, active_o, rx_req} !== 3'b101) begin fails++; $display("FAIL sendreq_flags: got %b want 101", {tx_valid, active_o, rx_req}); end
    checks++; if (tx_msg !== RETRAIN_REQ) begin fails++; $display("FAIL sendreq_msg: got %0h want %0h", tx_msg, RETRAIN_REQ); end
    checks++; if ({reset_retry, reset_state} !== 2'b00) begin fails++; $display("FAIL sendreq_timers: got %b want 00", {reset_retry, reset_state}); end
    send_next = 1'b1;
    step();
    send_next = 1'b0;
    checks++; if (tx_valid !== 1'b0) begin fails++; $display("FAIL req_accepted: got %0b want 0", tx_valid); end
    step(2);
    rx_valid = 1'b1; rx_msg = RETRAIN_RESP;
    step();
    rx_valid = 1'b0; rx_msg = SB_NO_MSG;
    checks++; if ({exit_retrain_o, active_o, tx_valid} !== 3'b100) begin fails++; $display("FAIL local_exit_rt: got %b want 100", {exit_retrain_o, active_o, tx_valid}); end
    step(5);
    checks++; if (exit_retrain_o !== 1'b1) begin fails++; $display("FAIL exit_rt_sticky: got %0b want 1", exit_retrain_o); end
    enable_i = 1'b0;
    step();
    checks++; if ({exit_retrain_o, reset_retry, reset_state} !== 3'b011) begin fails++; $display("FAIL disable_clear: got %b want 011", {exit_retrain_o, reset_retry, reset_state}); end
    enable_i = 1'b1;
    step();
  endtask

  task automatic test_crossing();
    rx_valid = 1'b1; rx_msg = RETRAIN_REQ; retrain_req_i = 1'b1;
    step();
    rx_valid = 1'b0; rx_msg = SB_NO_MSG; retrain_req_i = 1'b0;
    checks++; if (tx_valid !== 1'b1) begin fails++; $display("FAIL cross_valid: got %0b want 1", tx_valid); end
    checks++; if (tx_msg !== RETRAIN_RESP) begin fails++; $display("FAIL cross_msg: got %0h want %0h", tx_msg, RETRAIN_RESP); end
    send_next = 1'b1;
    step();
    send_next = 1'b0;
    checks++; if ({exit_retrain_o, tx_valid} !== 2'b10) begin fails++; $display("FAIL cross_exit_rt: got %b want 10", {exit_retrain_o, tx_valid}); end
    step(3);
    checks++; if (tx_valid !== 1'b0) begin fails++; $display("FAIL cross_no_req: got %0b want 0", tx_valid); end
    go_active();
  endtask

  task automatic test_retry_exhaust();
    int sends;
    sends = 0;
    retrain_req_i = 1'b1;
    step();
    retrain_req_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (tx_valid !== 1'b1 || tx_msg !== RETRAIN_REQ) begin fails++; $display("FAIL retry_send%0d: got valid %0b msg %0h want 1 %0h", i, tx_valid, tx_msg, RETRAIN_REQ); end
      if (tx_valid && tx_msg == RETRAIN_REQ) sends++;
      send_next = 1'b1;
      step();
      send_next = 1'b0;
      step(2);
      retry_to = 1'b1;
      step();
      retry_to = 1'b0;
      if (i < 3) begin
        checks++; if (reset_retry !== 1'b1) begin fails++; $display("FAIL retry_pulse%0d: got %0b want 1", i, reset_retry); end
      end
    end
    checks++; if (sends !== 4) begin fails++; $display("FAIL retry_send_count: got %0d want 4", sends); end
    checks++; if (tx_valid !== 1'b1 || tx_msg !== TRAINERROR_REQ) begin fails++; $display("FAIL retry_te_msg: got valid %0b msg %0h want 1 %0h", tx_valid, tx_msg, TRAINERROR_REQ); end
    send_next = 1'b1;
    step();
    send_next = 1'b0;
    checks++; if ({exit_trainerror_o, active_o, tx_valid} !== 3'b100) begin fails++; $display("FAIL retry_error: got %b want 100", {exit_trainerror_o, active_o, tx_valid}); end
    state_to = 1'b1;
    step(3);
    state_to = 1'b0;
    checks++; if ({exit_trainerror_o, tx_valid} !== 2'b10) begin fails++; $display("FAIL error_ignores_timeout: got %b want 10", {exit_trainerror_o, tx_valid}); end
    go_active();
  endtask

  task automatic test_state_timeout();
    retrain_req_i = 1'b1;
    step();
    retrain_req_i = 1'b0;
    send_next = 1'b1;
    step();
    send_next = 1'b0;
    state_to = 1'b1;
    step();
    state_to = 1'b0;
    checks++; if (tx_valid !== 1'b1 || tx_msg !== TRAINERROR_REQ) begin fails++; $display("FAIL stto_te_msg: got valid %0b msg %0h want 1 %0h", tx_valid, tx_msg, TRAINERROR_REQ); end
    send_next = 1'b1;
    step();
    send_next = 1'b0;
    checks++; if (exit_trainerror_o !== 1'b1) begin fails++; $display("FAIL stto_error: got %0b want 1", exit_trainerror_o); end
    go_active();
  endtask

  task automatic test_remote_trainerror();
    rx_valid = 1'b1; rx_msg = TRAINERROR_REQ;
    step();
    rx_valid = 1'b0; rx_msg = SB_NO_MSG;
    checks++; if ({exit_trainerror_o, active_o} !== 2'b10) begin fails++; $display("FAIL remote_te: got %b want 10", {exit_trainerror_o, active_o}); end
    go_active();
  endtask

  task automatic test_disable_mid_req();
    retrain_req_i = 1'b1;
    step();
    retrain_req_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(2);
      retry_to = 1'b1;
      step();
      retry_to = 1'b0;
    end
    checks++; if (tx_valid !== 1'b1) begin fails++; $display("FAIL mid_req_valid: got %0b want 1", tx_valid); end
    enable_i = 1'b0;
    step();
    checks++; if ({tx_valid, active_o, rx_req, exit_retrain_o, exit_trainerror_o} !== 5'b00000) begin fails++; $display("FAIL mid_disable: got %b want 00000", {tx_valid, active_o, rx_req, exit_retrain_o, exit_trainerror_o}); end
    checks++; if ({reset_retry, reset_state} !== 2'b11) begin fails++; $display("FAIL mid_disable_timers: got %b want 11", {reset_retry, reset_state}); end
    enable_i = 1'b1;
    step();
    checks++; if (active_o !== 1'b1) begin fails++; $display("FAIL reenable_active: got %0b want 1", active_o); end
    retrain_req_i = 1'b1;
    step();
    retrain_req_i = 1'b0;
    step(2);
    retry_to = 1'b1;
    step();
    retry_to = 1'b0;
    checks++; if (tx_valid !== 1'b1 || tx_msg !== RETRAIN_REQ) begin fails++; $display("FAIL count_cleared: got valid %0b msg %0h want 1 %0h", tx_valid, tx_msg, RETRAIN_REQ); end
  endtask

  initial begin
    reset = 1'b0; enable_i = 1'b0; retrain_req_i = 1'b0;
    send_next = 1'b0; rx_valid = 1'b0; rx_msg = SB_NO_MSG;
    retry_to = 1'b0; state_to = 1'b0;
    test_reset();
    test_enable();
    test_local_retrain();
    test_crossing();
    test_retry_exhaust();
    test_state_timeout();
    test_remote_trainerror();
    test_disable_mid_req();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
